bcd_seg_scanner: RTL

Sequential display stage that consumes the three BCD digits (hundreds, tens, ones) produced by the binary-to-BCD converter. It drives a time-multiplexed 3-digit common-anode seven-segment display. Digits are double-buffered so a frame never shows a mix of old and new values. Leading zeros are optionally blanked, and a ghosting gap separates successive digits.

---
 rtl/bcd_display_pkg.sv | 22 ++
 rtl/bcd_to_seg7.sv | 23 ++
 rtl/bcd_seg_scanner.sv | 75 +++++++
 3 files changed

// File: rtl/bcd_display_pkg.sv
// bcd_display_pkg: seven-segment patterns, digit indices and slot states
// shared by the scanner and its decoder.
package bcd_display_pkg;
    localparam logic [6:0] SEG_0    = 7'b1000000;
    localparam logic [6:0] SEG_1    = 7'b1111001;
    localparam logic [6:0] SEG_2    = 7'b0100100;
    localparam logic [6:0] SEG_3    = 7'b0110000;
    localparam logic [6:0] SEG_4    = 7'b0011001;
    localparam logic [6:0] SEG_5    = 7'b0010010;
    localparam logic [6:0] SEG_6    = 7'b0000010;
    localparam logic [6:0] SEG_7    = 7'b1111000;
    localparam logic [6:0] SEG_8    = 7'b0000000;
    localparam logic [6:0] SEG_9    = 7'b0010000;
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_OFF  = 7'b1111111;

    localparam logic [1:0] DIG_ONES     = 2'd0;
    localparam logic [1:0] DIG_TENS     = 2'd1;
    localparam logic [1:0] DIG_HUNDREDS = 2'd2;

    typedef enum logic {SLOT_GAP, SLOT_SHOW} slot_e;
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: BCD digit to active-low {g..a} pattern; non-decimal codes become a dash.
module bcd_to_seg7
    import bcd_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);
    always_comb begin
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end
endmodule

// File: rtl/bcd_seg_scanner.sv
// bcd_seg_scanner: double-buffered 3-digit multiplexed common-anode display driver
// with anti-ghosting gap and optional leading-zero blanking.
module bcd_seg_scanner
    import bcd_display_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16,
    parameter int LZB       = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] ones,
    input  logic [3:0] tens,
    input  logic [3:0] hundreds,
    input  logic       load,
    output logic [6:0] seg,
    output logic [2:0] an,
    output logic       frame_tick
);
    localparam int CW = $clog2(SCAN_DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    dig_q, dig_d;
    logic [11:0]   pend_q, pend_d, disp_q, disp_d;
    logic [6:0]    seg_q, seg_d, seg_raw;
    logic [2:0]    an_q, an_d;
    logic          tick_q, tick_d;
    logic          wrap, boundary, blank, lit;
    logic [3:0]    cur;
    slot_e         slot;

    bcd_to_seg7 u_dec (.bcd(cur), .seg(seg_raw));

    always_comb begin
        wrap     = cnt_q == CW'(SCAN_DIV - 1);
        boundary = wrap && dig_q == DIG_HUNDREDS;
        cnt_d    = wrap ? '0 : cnt_q + CW'(1);
        dig_d    = !wrap ? dig_q : (dig_q == DIG_HUNDREDS ? DIG_ONES : dig_q + 2'd1);
        pend_d   = load ? {hundreds, tens, ones} : pend_q;
        // pend_d already carries the live inputs when load coincides with the boundary
        disp_d   = boundary ? pend_d : disp_q;
        slot     = cnt_q < CW'(BLANK_CYC) ? SLOT_GAP : SLOT_SHOW;
        cur      = dig_q == DIG_HUNDREDS ? disp_q[11:8] : dig_q == DIG_TENS ? disp_q[7:4] : disp_q[3:0];
        blank    = LZB != 0 && (dig_q == DIG_HUNDREDS ? disp_q[11:8] == 4'd0 :
                                dig_q == DIG_TENS ? disp_q[11:4] == 8'd0 : 1'b0);
        lit      = slot == SLOT_SHOW && !blank;
        an_d     = lit ? ~(3'b001 << dig_q) : 3'b111;
        seg_d    = lit ? seg_raw : SEG_OFF;
        tick_d   = boundary;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            dig_q  <= DIG_ONES;
            pend_q <= '0;
            disp_q <= '0;
            an_q   <= 3'b111;
            seg_q  <= SEG_OFF;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            dig_q  <= dig_d;
            pend_q <= pend_d;
            disp_q <= disp_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
            tick_q <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = tick_q;
endmodule
